// File: rtl/sort_mem_arbiter.sv
// Round-robin arbiter sharing one 1R/1W sort memory (1-cycle registered read) among NREQ requesters.
// Latency: gnt/mem enables same cycle, rvalid one cycle after a read grant; optional SORT_MEM_ARB_LOCK_EN adds ownership locking.
module sort_mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_rdaddr,
  output logic [AW-1:0]        mem_wraddr,
  output logic [DW-1:0]        mem_in,
  input  logic [DW-1:0]        mem_out
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic            grant;
  logic [IW:0]     sum;
  logic [IW-1:0]   idx;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] rvalid_q;

`ifdef SORT_MEM_ARB_LOCK_EN
  logic            owner_vld;
  logic [IW-1:0]   owner;
  logic            owner_rel;
`else
  logic            lock_unused;
  assign lock_unused = ^lock;
`endif

  // Search starts just after the previous winner, wrapping modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
`ifdef SORT_MEM_ARB_LOCK_EN
    if (owner_vld) begin
      win_vld = req[owner];
      win     = owner;
    end
`endif
  end

  assign grant = nrst && win_vld;

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign gnt        = grant ? win_oh : '0;
  assign mem_wr     = grant && we[win];
  assign mem_rd     = grant && !we[win];
  assign mem_wraddr = mem_wr ? addr[int'(win)*AW +: AW]  : '0;
  assign mem_in     = mem_wr ? wdata[int'(win)*DW +: DW] : '0;
  assign mem_rdaddr = mem_rd ? addr[int'(win)*AW +: AW]  : '0;

  // Gated by nrst so a read granted just before reset never surfaces.
  assign rvalid = nrst ? rvalid_q : '0;
  assign rdata  = mem_out;

`ifdef SORT_MEM_ARB_LOCK_EN
  assign owner_rel = owner_vld && (!req[owner] || (grant && !lock[owner]));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      owner_vld <= 1'b0;
      owner     <= '0;
    end else if (owner_rel) begin
      owner_vld <= 1'b0;
    end else if (!owner_vld && grant && lock[win]) begin
      owner_vld <= 1'b1;
      owner     <= win;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      last     <= IW'(NREQ-1);
      rvalid_q <= '0;
    end else begin
      rvalid_q <= mem_rd ? win_oh : '0;
      if (grant) last <= win;
`ifdef SORT_MEM_ARB_LOCK_EN
      else if (owner_rel) last <= owner;
`endif
    end
  end

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Directed bench for sort_mem_arbiter with a behavioural 8x8 registered-read memory.
module tb_sort_mem_arbiter;
  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] req, we, lock, gnt, rvalid;
  logic [5:0] addr;
  logic [15:0] wdata;
  logic [7:0] rdata, mem_in, mem_out;
  logic       mem_rd, mem_wr;
  logic [2:0] mem_rdaddr, mem_wraddr;
  logic [7:0] mem [8];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sort_mem_arbiter #(.NREQ(2), .AW(3), .DW(8)) dut (
    .clk(clk), .nrst(nrst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdaddr(mem_rdaddr), .mem_wraddr(mem_wraddr),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always @(posedge clk) begin
    if (mem_wr) mem[mem_wraddr] <= mem_in;
    if (mem_rd) mem_out <= mem[mem_rdaddr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after posedge, then settle to the negedge for checks.
  task automatic step(input logic n, input logic [1:0] r, input logic [1:0] w,
                      input logic [2:0] a0, input logic [2:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] l);
    @(posedge clk);
    #1;
    nrst = n; req = r; we = w; addr = {a1, a0}; wdata = {d1, d0}; lock = l;
    @(negedge clk);
  endtask

  logic [1:0] exp_g [6];
  logic [1:0] exp6 [6];

  initial begin
    nrst = 1'b0; req = 2'b11; we = 2'b00; addr = '0; wdata = '0; lock = 2'b00;

    // 1: reset with all requests asserted
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 2'b00);
      chk("rst_gnt", 16'(gnt), 16'h0);
      chk("rst_rvalid", 16'(rvalid), 16'h0);
      chk("rst_rd", 16'(mem_rd), 16'h0);
      chk("rst_wr", 16'(mem_wr), 16'h0);
      chk("rst_rdaddr", 16'(mem_rdaddr), 16'h0);
    end

    // 2: write then read same address
    step(1'b1, 2'b01, 2'b01, 3'd3, 3'd0, 8'h5A, 8'h00, 2'b00);
    chk("wr_gnt", 16'(gnt), 16'h1);
    chk("wr_en", 16'({mem_wr, mem_rd}), 16'h2);
    chk("wr_addr", 16'(mem_wraddr), 16'h3);
    chk("wr_data", 16'(mem_in), 16'h5A);
    step(1'b1, 2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00);
    chk("rd_gnt", 16'(gnt), 16'h1);
    chk("rd_en", 16'({mem_wr, mem_rd}), 16'h1);
    chk("rd_addr", 16'(mem_rdaddr), 16'h3);
    chk("rd_rvalid_early", 16'(rvalid), 16'h0);
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    chk("idle_gnt", 16'(gnt), 16'h0);
    chk("rd_rvalid", 16'(rvalid), 16'h1);
    chk("rd_rdata", 16'(rdata), 16'h5A);

    // 3: both requesters reading continuously alternate
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    step(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 2'b00);
      chk($sformatf("rr_gnt%0d", c), 16'(gnt), 16'(exp_g[c]));
      chk($sformatf("rr_rvalid%0d", c), 16'(rvalid), (c == 0) ? 16'h0 : 16'(exp_g[c-1]));
    end
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    chk("rr_rvalid_tail", 16'(rvalid), 16'h2);

    // 4: preload mem[2]=0x33, then contending read/write on address 2
    step(1'b1, 2'b01, 2'b01, 3'd2, 3'd0, 8'h33, 8'h00, 2'b00);
    chk("pre_wr", 16'({gnt, mem_wraddr, mem_in}), {2'b01, 3'd2, 8'h33});
    step(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    step(1'b1, 2'b11, 2'b10, 3'd2, 3'd2, 8'h00, 8'h11, 2'b00);
    chk("c_gnt0", 16'(gnt), 16'h1);
    chk("c_rd0", 16'(mem_rd), 16'h1);
    step(1'b1, 2'b11, 2'b10, 3'd2, 3'd2, 8'h00, 8'h11, 2'b00);
    chk("c_gnt1", 16'(gnt), 16'h2);
    chk("c_wr1", 16'({mem_wr, mem_wraddr, mem_in}), {1'b1, 3'd2, 8'h11});
    chk("c_old", 16'({rvalid, rdata}), {2'b01, 8'h33});
    step(1'b1, 2'b01, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00, 2'b00);
    chk("c_gnt2", 16'(gnt), 16'h1);
    chk("c_wr_rvalid", 16'(rvalid), 16'h0);
    step(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    chk("c_new", 16'({rvalid, rdata}), {2'b01, 8'h11});

    // 5: reset right after a read grant suppresses its rvalid
    step(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    step(1'b1, 2'b10, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 2'b00);
    chk("mr_gnt", 16'(gnt), 16'h2);
    step(1'b0, 2'b11, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 2'b00);
    chk("mr_rvalid", 16'(rvalid), 16'h0);
    chk("mr_gnt_rst", 16'(gnt), 16'h0);
    step(1'b1, 2'b11, 2'b00, 3'd0, 3'd4, 8'h00, 8'h00, 2'b00);
    chk("mr_first", 16'(gnt), 16'h1);
    chk("mr_rvalid_after", 16'(rvalid), 16'h0);

    // 6: lock held by requester 0 for four grants, then released
`ifdef SORT_MEM_ARB_LOCK_EN
    exp6 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    exp6 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    step(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 2'b11, 2'b00, 3'd5, 3'd6, 8'h00, 8'h00, (c < 4) ? 2'b01 : 2'b00);
      chk($sformatf("lk_gnt%0d", c), 16'(gnt), 16'(exp6[c]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
